// File: rtl/cmd_bundle_arbiter_if.sv
// Bundle-side and downstream-side signals of the command bundle arbiter.
// The master modport belongs to the environment: the bank schedulers and the
// timing checker. The slave modport belongs to the arbiter.
// Per-bank fields are flattened, so that bank b occupies [b*W +: W].
interface cmd_bundle_arbiter_if #(
  parameter int CH_WIDTH       = 1,
  parameter int RNK_WIDTH      = 1,
  parameter int BG_WIDTH       = 1,
  parameter int BNK_WIDTH      = 2,
  parameter int ROW_WIDTH      = 17,
  parameter int COL_WIDTH      = 10,
  parameter int PTR_WIDTH      = 6,
  parameter int CMD_TYPE_WIDTH = 3,
  parameter int NUM_BNK_TOT    = 8
);
  logic [NUM_BNK_TOT-1:0]                pre_bundle_valid;
  logic [NUM_BNK_TOT-1:0]                act_bundle_valid;
  logic [NUM_BNK_TOT-1:0]                cas_bundle_valid;
  logic [CMD_TYPE_WIDTH*NUM_BNK_TOT-1:0] pre_bundle_cmd;
  logic [CMD_TYPE_WIDTH*NUM_BNK_TOT-1:0] act_bundle_cmd;
  logic [CMD_TYPE_WIDTH*NUM_BNK_TOT-1:0] cas_bundle_cmd;
  logic [CH_WIDTH*NUM_BNK_TOT-1:0]       i_channel;
  logic [RNK_WIDTH*NUM_BNK_TOT-1:0]      i_rank;
  logic [BG_WIDTH*NUM_BNK_TOT-1:0]       i_group;
  logic [BNK_WIDTH*NUM_BNK_TOT-1:0]      i_bank;
  logic [ROW_WIDTH*NUM_BNK_TOT-1:0]      i_row;
  logic [COL_WIDTH*NUM_BNK_TOT-1:0]      i_column;
  logic [PTR_WIDTH*NUM_BNK_TOT-1:0]      i_ptr;
  logic                                  block_from_mc_refresh;
  logic [NUM_BNK_TOT-1:0]                pre_grant;
  logic [NUM_BNK_TOT-1:0]                act_grant;
  logic [NUM_BNK_TOT-1:0]                cas_grant;
  logic                                  cmd_valid;
  logic                                  cmd_ready;
  logic [CMD_TYPE_WIDTH-1:0]             cmd_type;
  logic [CH_WIDTH-1:0]                   cmd_channel;
  logic [RNK_WIDTH-1:0]                  cmd_rank;
  logic [BG_WIDTH-1:0]                   cmd_group;
  logic [BNK_WIDTH-1:0]                  cmd_bank;
  logic [ROW_WIDTH-1:0]                  cmd_row;
  logic [COL_WIDTH-1:0]                  cmd_column;
  logic [PTR_WIDTH-1:0]                  cmd_ptr;
  logic [1:0]                            cmd_class;

  modport master (
    output pre_bundle_valid, act_bundle_valid, cas_bundle_valid,
    output pre_bundle_cmd, act_bundle_cmd, cas_bundle_cmd,
    output i_channel, i_rank, i_group, i_bank, i_row, i_column, i_ptr,
    output block_from_mc_refresh, cmd_ready,
    input  pre_grant, act_grant, cas_grant,
    input  cmd_valid, cmd_type, cmd_channel, cmd_rank, cmd_group, cmd_bank,
    input  cmd_row, cmd_column, cmd_ptr, cmd_class
  );

  modport slave (
    input  pre_bundle_valid, act_bundle_valid, cas_bundle_valid,
    input  pre_bundle_cmd, act_bundle_cmd, cas_bundle_cmd,
    input  i_channel, i_rank, i_group, i_bank, i_row, i_column, i_ptr,
    input  block_from_mc_refresh, cmd_ready,
    output pre_grant, act_grant, cas_grant,
    output cmd_valid, cmd_type, cmd_channel, cmd_rank, cmd_group, cmd_bank,
    output cmd_row, cmd_column, cmd_ptr, cmd_class
  );
endinterface

// File: rtl/cmd_bundle_arbiter.sv
// Per-channel PRE/ACT/CAS bundle arbiter.
// Each cycle it picks at most one bundle and captures it into a one-entry
// output register, which is drained through a valid/ready handshake.
// Class priority is CAS > ACT > PRE. Within a class, the banks are served
// round-robin.
// Optional: define CMD_ARB_AGE_EN to add starvation counters for ACT and PRE.
// A class whose counter has reached AGE_LIMIT outranks CAS.
module cmd_bundle_arbiter #(
  parameter int CH_WIDTH       = 1,
  parameter int RNK_WIDTH      = 1,
  parameter int BG_WIDTH       = 1,
  parameter int BNK_WIDTH      = 2,
  parameter int ROW_WIDTH      = 17,
  parameter int COL_WIDTH      = 10,
  parameter int PTR_WIDTH      = 6,
  parameter int CMD_TYPE_WIDTH = 3,
  parameter int NUM_BNK_TOT    = 8,
  parameter int AGE_LIMIT      = 16,
  parameter int TCQ            = 100
) (
  input logic           clk,
  input logic           rst,
  cmd_bundle_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_BNK_TOT > 1) ? $clog2(NUM_BNK_TOT) : 1;
  typedef logic [IDX_W-1:0] idx_t;
  localparam logic [NUM_BNK_TOT-1:0] ONE = {{(NUM_BNK_TOT-1){1'b0}}, 1'b1};

  // TCQ describes register timing to the surrounding flow. No synthesizable
  // logic consumes it, and AGE_LIMIT is unused when ageing is compiled out.
  logic unused_cfg;
  assign unused_cfg = (TCQ < 0) | (AGE_LIMIT < 0);

  // Returns the first requester at or above ptr, wrapping past the top bank.
  function automatic idx_t rr_pick(input logic [NUM_BNK_TOT-1:0] req, input idx_t ptr);
    idx_t win;
    logic hit;
    int   idx;
    win = ptr;
    hit = 1'b0;
    for (int i = 0; i < NUM_BNK_TOT; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_BNK_TOT) idx = idx - NUM_BNK_TOT;
      if (!hit && req[idx_t'(idx)]) begin
        win = idx_t'(idx);
        hit = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic idx_t rr_next(input idx_t win);
    return (int'(win) == NUM_BNK_TOT - 1) ? '0 : win + 1'b1;
  endfunction

  logic                      cmd_valid_q, cmd_valid_d;
  logic [CMD_TYPE_WIDTH-1:0] cmd_type_q, cmd_type_d;
  logic [CH_WIDTH-1:0]       cmd_channel_q, cmd_channel_d;
  logic [RNK_WIDTH-1:0]      cmd_rank_q, cmd_rank_d;
  logic [BG_WIDTH-1:0]       cmd_group_q, cmd_group_d;
  logic [BNK_WIDTH-1:0]      cmd_bank_q, cmd_bank_d;
  logic [ROW_WIDTH-1:0]      cmd_row_q, cmd_row_d;
  logic [COL_WIDTH-1:0]      cmd_column_q, cmd_column_d;
  logic [PTR_WIDTH-1:0]      cmd_ptr_q, cmd_ptr_d;
  logic [1:0]                cmd_class_q, cmd_class_d;
  idx_t                      rr_pre_q, rr_pre_d, rr_act_q, rr_act_d, rr_cas_q, rr_cas_d;

  logic can_load, cas_elig, act_elig, pre_elig;
  logic sel_cas, sel_act, sel_pre, grant_any;
  idx_t cas_win, act_win, pre_win, win;

`ifdef CMD_ARB_AGE_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);
  logic [AGE_W-1:0] age_act_q, age_act_d, age_pre_q, age_pre_d;
  logic             act_aged, pre_aged;
  assign act_aged = (age_act_q == AGE_MAX);
  assign pre_aged = (age_pre_q == AGE_MAX);
`endif

  assign cas_win = rr_pick(bus.cas_bundle_valid, rr_cas_q);
  assign act_win = rr_pick(bus.act_bundle_valid, rr_act_q);
  assign pre_win = rr_pick(bus.pre_bundle_valid, rr_pre_q);

  // Class selection: at most one class wins, and only when the output register can load.
  always_comb begin
    can_load = ~cmd_valid_q | bus.cmd_ready;
    cas_elig = |bus.cas_bundle_valid;
    act_elig = (|bus.act_bundle_valid) & ~bus.block_from_mc_refresh;
    pre_elig = |bus.pre_bundle_valid;
    sel_cas  = 1'b0;
    sel_act  = 1'b0;
    sel_pre  = 1'b0;
    if (can_load) begin
`ifdef CMD_ARB_AGE_EN
      if (act_elig && act_aged)      sel_act = 1'b1;
      else if (pre_elig && pre_aged) sel_pre = 1'b1;
      else if (cas_elig)             sel_cas = 1'b1;
      else if (act_elig)             sel_act = 1'b1;
      else if (pre_elig)             sel_pre = 1'b1;
`else
      if (cas_elig)      sel_cas = 1'b1;
      else if (act_elig) sel_act = 1'b1;
      else if (pre_elig) sel_pre = 1'b1;
`endif
    end
  end

  assign grant_any     = sel_cas | sel_act | sel_pre;
  assign win           = sel_cas ? cas_win : (sel_act ? act_win : pre_win);
  assign bus.cas_grant = sel_cas ? (ONE << cas_win) : '0;
  assign bus.act_grant = sel_act ? (ONE << act_win) : '0;
  assign bus.pre_grant = sel_pre ? (ONE << pre_win) : '0;

  // Next state: capture the winner's bundle and advance the winning class pointer.
  always_comb begin
    cmd_valid_d   = cmd_valid_q;
    cmd_type_d    = cmd_type_q;
    cmd_channel_d = cmd_channel_q;
    cmd_rank_d    = cmd_rank_q;
    cmd_group_d   = cmd_group_q;
    cmd_bank_d    = cmd_bank_q;
    cmd_row_d     = cmd_row_q;
    cmd_column_d  = cmd_column_q;
    cmd_ptr_d     = cmd_ptr_q;
    cmd_class_d   = cmd_class_q;
    rr_cas_d      = sel_cas ? rr_next(cas_win) : rr_cas_q;
    rr_act_d      = sel_act ? rr_next(act_win) : rr_act_q;
    rr_pre_d      = sel_pre ? rr_next(pre_win) : rr_pre_q;
    if (grant_any) begin
      cmd_valid_d = 1'b1;
      if (sel_cas) begin
        cmd_type_d  = bus.cas_bundle_cmd[int'(win)*CMD_TYPE_WIDTH +: CMD_TYPE_WIDTH];
        cmd_class_d = 2'd2;
      end else if (sel_act) begin
        cmd_type_d  = bus.act_bundle_cmd[int'(win)*CMD_TYPE_WIDTH +: CMD_TYPE_WIDTH];
        cmd_class_d = 2'd1;
      end else begin
        cmd_type_d  = bus.pre_bundle_cmd[int'(win)*CMD_TYPE_WIDTH +: CMD_TYPE_WIDTH];
        cmd_class_d = 2'd0;
      end
      cmd_channel_d = bus.i_channel[int'(win)*CH_WIDTH +: CH_WIDTH];
      cmd_rank_d    = bus.i_rank[int'(win)*RNK_WIDTH +: RNK_WIDTH];
      cmd_group_d   = bus.i_group[int'(win)*BG_WIDTH +: BG_WIDTH];
      cmd_bank_d    = bus.i_bank[int'(win)*BNK_WIDTH +: BNK_WIDTH];
      cmd_row_d     = bus.i_row[int'(win)*ROW_WIDTH +: ROW_WIDTH];
      cmd_column_d  = bus.i_column[int'(win)*COL_WIDTH +: COL_WIDTH];
      cmd_ptr_d     = bus.i_ptr[int'(win)*PTR_WIDTH +: PTR_WIDTH];
    end else if (bus.cmd_ready) begin
      cmd_valid_d = 1'b0;
    end
  end

  // Output register and round-robin pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid_q   <= 1'b0;
      cmd_type_q    <= '0;
      cmd_channel_q <= '0;
      cmd_rank_q    <= '0;
      cmd_group_q   <= '0;
      cmd_bank_q    <= '0;
      cmd_row_q     <= '0;
      cmd_column_q  <= '0;
      cmd_ptr_q     <= '0;
      cmd_class_q   <= '0;
      rr_pre_q      <= '0;
      rr_act_q      <= '0;
      rr_cas_q      <= '0;
    end else begin
      cmd_valid_q   <= cmd_valid_d;
      cmd_type_q    <= cmd_type_d;
      cmd_channel_q <= cmd_channel_d;
      cmd_rank_q    <= cmd_rank_d;
      cmd_group_q   <= cmd_group_d;
      cmd_bank_q    <= cmd_bank_d;
      cmd_row_q     <= cmd_row_d;
      cmd_column_q  <= cmd_column_d;
      cmd_ptr_q     <= cmd_ptr_d;
      cmd_class_q   <= cmd_class_d;
      rr_pre_q      <= rr_pre_d;
      rr_act_q      <= rr_act_d;
      rr_cas_q      <= rr_cas_d;
    end
  end

`ifdef CMD_ARB_AGE_EN
  // Starvation counters: count the cycles in which a class is eligible and loses.
  // A counter clears once its class is served or goes idle.
  always_comb begin
    age_act_d = age_act_q;
    age_pre_d = age_pre_q;
    if (sel_act || !(|bus.act_bundle_valid))
      age_act_d = '0;
    else if (act_elig && can_load && !act_aged)
      age_act_d = age_act_q + 1'b1;
    if (sel_pre || !(|bus.pre_bundle_valid))
      age_pre_d = '0;
    else if (pre_elig && can_load && !pre_aged)
      age_pre_d = age_pre_q + 1'b1;
  end

  // Age counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_act_q <= '0;
      age_pre_q <= '0;
    end else begin
      age_act_q <= age_act_d;
      age_pre_q <= age_pre_d;
    end
  end
`endif

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_type    = cmd_type_q;
  assign bus.cmd_channel = cmd_channel_q;
  assign bus.cmd_rank    = cmd_rank_q;
  assign bus.cmd_group   = cmd_group_q;
  assign bus.cmd_bank    = cmd_bank_q;
  assign bus.cmd_row     = cmd_row_q;
  assign bus.cmd_column  = cmd_column_q;
  assign bus.cmd_ptr     = cmd_ptr_q;
  assign bus.cmd_class   = cmd_class_q;
endmodule

// File: tb/tb_cmd_bundle_arbiter.sv
// Self-checking bench for cmd_bundle_arbiter.
// It runs a directed vector table, hand-written reset and ageing sequences, and
// randomized traffic checked against a class/round-robin reference model.
module tb_cmd_bundle_arbiter;
  localparam int N    = 8;
  localparam int CT   = 3;
  localparam int ROWW = 17;
  localparam int COLW = 10;
  localparam int PTRW = 6;
  localparam int AGE_LIM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_bundle_arbiter_if #(.CH_WIDTH(1), .RNK_WIDTH(1), .BG_WIDTH(1), .BNK_WIDTH(2),
    .ROW_WIDTH(ROWW), .COL_WIDTH(COLW), .PTR_WIDTH(PTRW), .CMD_TYPE_WIDTH(CT),
    .NUM_BNK_TOT(N)) bus ();

  cmd_bundle_arbiter #(.CH_WIDTH(1), .RNK_WIDTH(1), .BG_WIDTH(1), .BNK_WIDTH(2),
    .ROW_WIDTH(ROWW), .COL_WIDTH(COLW), .PTR_WIDTH(PTRW), .CMD_TYPE_WIDTH(CT),
    .NUM_BNK_TOT(N), .AGE_LIMIT(AGE_LIM), .TCQ(100)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model state. The class index is 0 PRE, 1 ACT, 2 CAS.
  logic            m_valid;
  logic [1:0]      m_class;
  logic [CT-1:0]   m_type;
  logic [ROWW-1:0] m_row;
  logic [COLW-1:0] m_col;
  logic [PTRW-1:0] m_ptr;
  logic [1:0]      m_bank;
  int              m_rr[3];
  int              m_age[2];
  // Values the model computes for the coming clock edge.
  logic [3*N-1:0]  exp_g;
  int              exp_cls, exp_win;
  logic            n_valid;
  logic [CT-1:0]   n_type;
  logic [ROWW-1:0] n_row;
  logic [COLW-1:0] n_col;
  logic [PTRW-1:0] n_ptr;
  logic [1:0]      n_bank;
  int              n_age[2];

  task automatic model_reset();
    m_valid = 0; m_class = 0; m_type = 0; m_row = 0; m_col = 0; m_ptr = 0; m_bank = 0;
    for (int c = 0; c < 3; c++) m_rr[c] = 0;
    m_age[0] = 0; m_age[1] = 0;
  endtask

  // The winner is the requester with the smallest upward distance from the pointer.
  function automatic int rr_win(input logic [N-1:0] req, input int ptr);
    int best = -1;
    int bd = N;
    for (int b = 0; b < N; b++)
      if (req[b] && ((b - ptr + N) % N) < bd) begin
        bd = (b - ptr + N) % N;
        best = b;
      end
    return best;
  endfunction

  task automatic model_eval();
    logic [N-1:0] req[3];
    logic elig[3];
    logic cl;
    logic [CT*N-1:0] cmdv;
    req[0] = bus.pre_bundle_valid; req[1] = bus.act_bundle_valid; req[2] = bus.cas_bundle_valid;
    elig[0] = |req[0];
    elig[1] = (|req[1]) && !bus.block_from_mc_refresh;
    elig[2] = |req[2];
    cl = !m_valid || bus.cmd_ready;
    exp_cls = -1;
    if (cl) begin
`ifdef CMD_ARB_AGE_EN
      if (elig[1] && m_age[1] == AGE_LIM) exp_cls = 1;
      else if (elig[0] && m_age[0] == AGE_LIM) exp_cls = 0;
`endif
      for (int c = 2; c >= 0; c--) if (exp_cls < 0 && elig[c]) exp_cls = c;
    end
    exp_g = '0;
    n_valid = m_valid; n_type = m_type; n_row = m_row; n_col = m_col; n_ptr = m_ptr; n_bank = m_bank;
    if (exp_cls >= 0) begin
      exp_win = rr_win(req[exp_cls], m_rr[exp_cls]);
      exp_g[exp_cls*N + exp_win] = 1'b1;
      cmdv = (exp_cls == 2) ? bus.cas_bundle_cmd : (exp_cls == 1) ? bus.act_bundle_cmd : bus.pre_bundle_cmd;
      n_valid = 1;
      n_type  = cmdv[exp_win*CT +: CT];
      n_row   = bus.i_row[exp_win*ROWW +: ROWW];
      n_col   = bus.i_column[exp_win*COLW +: COLW];
      n_ptr   = bus.i_ptr[exp_win*PTRW +: PTRW];
      n_bank  = bus.i_bank[exp_win*2 +: 2];
    end else if (bus.cmd_ready) begin
      n_valid = 0;
    end
    for (int c = 0; c < 2; c++) begin
      n_age[c] = m_age[c];
      if (exp_cls == c || req[c] == 0) n_age[c] = 0;
      else if (elig[c] && cl && m_age[c] < AGE_LIM) n_age[c] = m_age[c] + 1;
    end
  endtask

  task automatic model_commit();
    if (exp_cls >= 0) begin
      m_class = 2'(exp_cls);
      m_rr[exp_cls] = (exp_win + 1) % N;
    end
    m_valid = n_valid; m_type = n_type; m_row = n_row; m_col = n_col; m_ptr = n_ptr; m_bank = n_bank;
    m_age[0] = n_age[0]; m_age[1] = n_age[1];
  endtask

  task automatic check_regs();
    chk("cmd_valid", bus.cmd_valid, m_valid);
    chk("cmd_class", bus.cmd_class, m_class);
    chk("cmd_type",  bus.cmd_type,  m_type);
    chk("cmd_row",   bus.cmd_row,   m_row);
    chk("cmd_column", bus.cmd_column, m_col);
    chk("cmd_ptr",   bus.cmd_ptr,   m_ptr);
    chk("cmd_bank",  bus.cmd_bank,  m_bank);
  endtask

  // Called mid-cycle with the inputs stable. It returns 1 ns after the next rising edge.
  task automatic run_cycle();
    model_eval();
    chk("grants", {bus.cas_grant, bus.act_grant, bus.pre_grant}, exp_g);
    @(posedge clk); #1;
    model_commit();
    check_regs();
  endtask

  task automatic drive(input logic [N-1:0] p, input logic [N-1:0] a, input logic [N-1:0] c,
                       input logic blk, input logic rdy);
    bus.pre_bundle_valid = p; bus.act_bundle_valid = a; bus.cas_bundle_valid = c;
    bus.block_from_mc_refresh = blk; bus.cmd_ready = rdy;
  endtask

  task automatic drive_fields(input bit rnd);
    for (int b = 0; b < N; b++) begin
      bus.pre_bundle_cmd[b*CT +: CT] = rnd ? CT'($urandom) : 3'd2;
      bus.act_bundle_cmd[b*CT +: CT] = rnd ? CT'($urandom) : 3'd3;
      bus.cas_bundle_cmd[b*CT +: CT] = rnd ? CT'($urandom) : 3'd4;
      bus.i_channel[b]          = rnd ? 1'($urandom) : 1'b1;
      bus.i_rank[b]             = rnd ? 1'($urandom) : 1'b0;
      bus.i_group[b]            = rnd ? 1'($urandom) : 1'(b / 4);
      bus.i_bank[b*2 +: 2]      = rnd ? 2'($urandom) : 2'(b % 4);
      bus.i_row[b*ROWW +: ROWW] = rnd ? ROWW'($urandom) : ROWW'(b * 1000 + 7);
      bus.i_column[b*COLW +: COLW] = rnd ? COLW'($urandom) : COLW'(b * 100 + 3);
      bus.i_ptr[b*PTRW +: PTRW] = rnd ? PTRW'($urandom) : PTRW'(b * 7 + 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, '0, '0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check_regs();
  endtask

  typedef struct {
    logic [N-1:0] pre, act, cas;
    logic blk, rdy;
    logic [N-1:0] g_pre, g_act, g_cas;
    logic v;
    logic [1:0] cls;
  } vec_t;
  vec_t tbl[16];

  initial begin
    logic [ROWW-1:0] exp_row;
    logic [N-1:0] g;
    int hits[$];

    tbl[0]  = '{8'h00, 8'h00, 8'h05, 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b1, 2'd2};
    tbl[1]  = '{8'h00, 8'h00, 8'h05, 1'b0, 1'b1, 8'h00, 8'h00, 8'h04, 1'b1, 2'd2};
    tbl[2]  = '{8'h00, 8'h00, 8'h05, 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b1, 2'd2};
    tbl[3]  = '{8'h80, 8'h10, 8'h02, 1'b0, 1'b1, 8'h00, 8'h00, 8'h02, 1'b1, 2'd2};
    tbl[4]  = '{8'h80, 8'h10, 8'h00, 1'b0, 1'b1, 8'h00, 8'h10, 8'h00, 1'b1, 2'd1};
    tbl[5]  = '{8'h80, 8'h00, 8'h00, 1'b0, 1'b1, 8'h80, 8'h00, 8'h00, 1'b1, 2'd0};
    for (int i = 6; i <= 10; i++)
      tbl[i] = '{8'h00, 8'h01, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0};
    tbl[11] = '{8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 1'b1, 2'd1};
    tbl[12] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 2'd1};
    tbl[13] = '{8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 2'd1};
    tbl[14] = '{8'h00, 8'h00, 8'h01, 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b1, 2'd2};
    tbl[15] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 2'd2};

    drive_fields(0);
    do_reset();

    // Directed vectors, applied in sequence from reset.
    exp_row = '0;
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].pre, tbl[i].act, tbl[i].cas, tbl[i].blk, tbl[i].rdy);
      #4;
      chk($sformatf("tbl%0d_pre_grant", i), bus.pre_grant, tbl[i].g_pre);
      chk($sformatf("tbl%0d_act_grant", i), bus.act_grant, tbl[i].g_act);
      chk($sformatf("tbl%0d_cas_grant", i), bus.cas_grant, tbl[i].g_cas);
      g = tbl[i].g_pre | tbl[i].g_act | tbl[i].g_cas;
      for (int b = 0; b < N; b++) if (g[b]) exp_row = ROWW'(b * 1000 + 7);
      run_cycle();
      chk($sformatf("tbl%0d_valid", i), bus.cmd_valid, tbl[i].v);
      chk($sformatf("tbl%0d_class", i), bus.cmd_class, tbl[i].cls);
      chk($sformatf("tbl%0d_row", i), bus.cmd_row, exp_row);
    end

    // Asynchronous reset while a command is held, with no clock edge in between.
    drive('0, '0, 8'h01, 1'b0, 1'b0);
    #4; run_cycle();
    chk("pre_rst_valid", bus.cmd_valid, 1'b1);
    drive('0, '0, '0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.cmd_valid, 1'b0);
    chk("async_rst_row", bus.cmd_row, '0);
    chk("async_rst_class", bus.cmd_class, 2'd0);
    #1 rst = 1'b0;
    model_reset();
    run_cycle();
    drive('0, '0, 8'h0C, 1'b0, 1'b1);
    #4;
    chk("post_rst_first_grant", bus.cas_grant, 8'h04);
    run_cycle();

`ifdef CMD_ARB_AGE_EN
    // Starved PRE: constant CAS traffic with one PRE requester.
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      drive(8'h08, '0, 8'hFF, 1'b0, 1'b1);
      #4;
      if (bus.pre_grant == 8'h08) hits.push_back(c);
      run_cycle();
    end
    chk("age_first_pre", (hits.size() > 0) ? hits[0] : -1, 5);
    chk("age_second_pre", (hits.size() > 1) ? hits[1] : -1, 10);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive(N'($urandom & $urandom & $urandom), N'($urandom & $urandom),
            N'($urandom & $urandom & $urandom), ($urandom % 4) == 0, ($urandom % 4) != 0);
      drive_fields(1);
      #4;
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
